// File: rtl/spi_slave_unit_if.sv
// rtl/spi_slave_unit_if.sv - SPI pin and status bundle for spi_slave_unit
interface spi_slave_unit_if;
   logic       ss;
   logic       sck;
   logic       mosi;
   wire        miso;
   logic       led1;
   logic       led2;
   logic [7:0] dbg;

   // Design side: samples the SPI pins, drives miso and status
   modport slave (
      input  ss,
      input  sck,
      input  mosi,
      output miso,
      output led1,
      output led2,
      output dbg
   );

   // External master side: drives the SPI pins, observes miso and status
   modport master (
      output ss,
      output sck,
      output mosi,
      input  miso,
      input  led1,
      input  led2,
      input  dbg
   );
endinterface

// File: rtl/spi_slave_unit.sv
// rtl/spi_slave_unit.sv - SPI mode-0 slave, echoes last received byte; optional macro SPI_MISO_TRISTATE_EN
module spi_slave_unit (
   input  logic             clk,
   input  logic             rst_n,
   spi_slave_unit_if.slave  spi
);

   // Synchronizer chains: meta -> sync -> history, edges come from sync vs history
   logic       r_ss_meta, r_ss_sync, r_ss_hist;
   logic       r_sck_meta, r_sck_sync, r_sck_hist;
   logic       r_mosi_meta, r_mosi_sync, r_mosi_hist;

   // Byte engine state
   logic [2:0] r_bit_cnt;
   logic [7:0] r_rx_shift;
   logic [7:0] r_tx_shift;
   logic [7:0] r_tx_byte;
   logic [7:0] r_dbg;
   logic       r_led1;
   logic       r_led2;

   logic       w_ss_fall;
   logic       w_ss_rise;
   logic       w_sck_rise;
   logic       w_sck_fall;
   logic       w_selected;
   logic       w_miso_en;
   logic [7:0] w_rx_next;
   logic       w_byte_done;

   // Bring the asynchronous pins into the clk domain; idle values match a deselected bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ss_meta   <= 1'b1;
         r_ss_sync   <= 1'b1;
         r_ss_hist   <= 1'b1;
         r_sck_meta  <= 1'b0;
         r_sck_sync  <= 1'b0;
         r_sck_hist  <= 1'b0;
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
         r_mosi_hist <= 1'b0;
      end else begin
         r_ss_meta   <= spi.ss;
         r_ss_sync   <= r_ss_meta;
         r_ss_hist   <= r_ss_sync;
         r_sck_meta  <= spi.sck;
         r_sck_sync  <= r_sck_meta;
         r_sck_hist  <= r_sck_sync;
         r_mosi_meta <= spi.mosi;
         r_mosi_sync <= r_mosi_meta;
         r_mosi_hist <= r_mosi_sync;
      end
   end

   assign w_ss_fall  = r_ss_hist & ~r_ss_sync;
   assign w_ss_rise  = ~r_ss_hist & r_ss_sync;
   assign w_sck_rise = ~r_sck_hist & r_sck_sync;
   assign w_sck_fall = r_sck_hist & ~r_sck_sync;
   assign w_selected = ~r_ss_sync;

   // mosi is held stable around the sck rise, so the history stage is a safe sample point
   assign w_rx_next   = {r_rx_shift[6:0], r_mosi_hist};
   assign w_byte_done = (r_bit_cnt == 3'd7);

   // Shift engine: select edges frame bytes, sck rise samples, sck fall advances miso
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt  <= 3'd0;
         r_rx_shift <= 8'h00;
         r_tx_shift <= 8'h00;
         r_tx_byte  <= 8'h00;
         r_dbg      <= 8'h00;
         r_led1     <= 1'b0;
         r_led2     <= 1'b0;
      end else if (w_ss_fall) begin
         r_bit_cnt  <= 3'd0;
         r_rx_shift <= 8'h00;
         r_tx_shift <= r_tx_byte;
      end else if (w_ss_rise) begin
         r_bit_cnt  <= 3'd0;
         r_rx_shift <= 8'h00;
      end else if (w_selected) begin
         if (w_sck_rise) begin
            r_rx_shift <= w_rx_next;
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
               r_dbg     <= w_rx_next;
               r_tx_byte <= w_rx_next;
               r_led1    <= ~r_led1;
               r_led2    <= (w_rx_next == 8'hA5);
            end
         end else if (w_sck_fall) begin
            // Counter already wrapped on the 8th rise: start the next byte's echo
            if (r_bit_cnt == 3'd0) begin
               r_tx_shift <= r_tx_byte;
            end else begin
               r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
         end
      end
   end

   // History stage drops on the same edge that loads the tx register, so miso never shows a stale bit
   assign w_miso_en = ~r_ss_hist;

`ifdef SPI_MISO_TRISTATE_EN
   assign spi.miso = w_miso_en ? r_tx_shift[7] : 1'bz;
`else
   assign spi.miso = w_miso_en ? r_tx_shift[7] : 1'b0;
`endif

   assign spi.dbg  = r_dbg;
   assign spi.led1 = r_led1;
   assign spi.led2 = r_led2;

endmodule

// File: tb/tb_spi_slave_unit.sv
// tb/tb_spi_slave_unit.sv - scoreboard bench for spi_slave_unit
module tb_spi_slave_unit;

   localparam int HALF = 25;

   logic clk;
   logic rst_n;

   spi_slave_unit_if spi ();

   spi_slave_unit u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .spi   (spi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  tx_m;
   logic [7:0]  dbg_m;
   logic        led1_m;
   logic        led2_m;
   logic        q_miso [$];
   logic [9:0]  q_stat [$];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      tx_m   = 8'h00;
      dbg_m  = 8'h00;
      led1_m = 1'b0;
      led2_m = 1'b0;
      q_miso.delete();
      q_stat.delete();
   endtask

   task automatic check_idle_miso(input string tag);
      logic exp_bit;
`ifdef SPI_MISO_TRISTATE_EN
      exp_bit = 1'bz;
`else
      exp_bit = 1'b0;
`endif
      check(tag, {7'b0, spi.miso}, {7'b0, exp_bit});
   endtask

   // Clock nbits of b out MSB first; expected miso is the echo register at byte start
   task automatic send_bits(input logic [7:0] b, input int nbits);
      logic exp_bit;
      for (int i = 7; i > 7 - nbits; i--) q_miso.push_back(tx_m[i]);
      for (int i = 7; i > 7 - nbits; i--) begin
         spi.mosi = b[i];
         wait_clk(HALF);
         if (q_miso.size() > 0) begin
            exp_bit = q_miso.pop_front();
            check($sformatf("miso_bit%0d_of_%h", i, b), {7'b0, spi.miso}, {7'b0, exp_bit});
         end
         spi.sck = 1'b1;
         wait_clk(HALF);
         spi.sck = 1'b0;
      end
      if (nbits == 8) begin
         tx_m   = b;
         dbg_m  = b;
         led1_m = ~led1_m;
         led2_m = (b == 8'hA5);
         q_stat.push_back({led2_m, led1_m, dbg_m});
      end
   endtask

   task automatic check_status(input string tag);
      logic [9:0] e;
      wait_clk(10);
      if (q_stat.size() > 0) e = q_stat.pop_front();
      else                   e = {led2_m, led1_m, dbg_m};
      check({tag, "_dbg"},  spi.dbg, e[7:0]);
      check({tag, "_led1"}, {7'b0, spi.led1}, {7'b0, e[8]});
      check({tag, "_led2"}, {7'b0, spi.led2}, {7'b0, e[9]});
   endtask

   task automatic select();
      spi.ss = 1'b0;
      wait_clk(10);
   endtask

   task automatic deselect();
      spi.ss = 1'b1;
      wait_clk(10);
   endtask

   initial begin
      rst_n    = 1'b0;
      spi.ss   = 1'b1;
      spi.sck  = 1'b0;
      spi.mosi = 1'b0;
      model_reset();
      wait_clk(5);
      check_status("reset");
      check_idle_miso("reset_miso");
      rst_n = 1'b1;
      wait_clk(10);

      select();
      send_bits(8'hA5, 8);
      check_status("byte_a5");
      deselect();
      check_idle_miso("idle_miso_after_a5");

      select();
      send_bits(8'h3C, 8);
      check_status("byte_3c");
      deselect();

      select();
      send_bits(8'h12, 8);
      check_status("burst_first_12");
      send_bits(8'h34, 8);
      check_status("burst_second_34");
      deselect();

      select();
      send_bits(8'hF0, 5);
      deselect();
      check_status("partial_abort");
      select();
      send_bits(8'hA5, 8);
      check_status("after_partial_a5");
      deselect();

      select();
      send_bits(8'h6B, 3);
      spi.sck = 1'b1;
      wait_clk(4);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("midreset_dbg",  spi.dbg, dbg_m);
      check("midreset_led1", {7'b0, spi.led1}, {7'b0, led1_m});
      check("midreset_led2", {7'b0, spi.led2}, {7'b0, led2_m});
      check_idle_miso("midreset_miso");
      spi.sck = 1'b0;
      spi.ss  = 1'b1;
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(10);
      select();
      send_bits(8'hFF, 8);
      check_status("after_reset_ff");
      deselect();
      check_idle_miso("final_idle_miso");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
